id_ex_stage: RTL

//  ID/EX pipeline register with integrated load-use hazard detection. Latches decoded operands and

---
 rtl/id_ex_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A hazard or flush turns the EX slot into a bubble; a hazard also holds PC and IF/ID.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_Funct,
  input  logic [3:0]       id_ALUOp,
  input  logic [5:0]       id_ctrl,
  input  logic             id_uses_rs2,
  input  logic             flush,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_Funct,
  output logic [3:0]       ex_ALUOp,
  output logic [5:0]       ex_ctrl,
  output logic             stall_out,
  output logic [CNT_W-1:0] stall_count
);

  // id_ctrl = {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc}
  localparam int MEMREAD_BIT = 3;

  logic             valid_q;
  logic [XLEN-1:0]  pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic [3:0]       funct_q, aluop_q;
  logic [5:0]       ctrl_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  logic             bubble;

  always_comb begin
    hz = valid_q & ctrl_q[MEMREAD_BIT] & id_valid & (rd_q != 5'd0) &
         ((rd_q == id_rs1) | (id_uses_rs2 & (rd_q == id_rs2)));
    stall_out = hz & ~flush;
    bubble    = flush | hz;
    // Counts only stalls actually taken; a flushed hazard is discarded upstream.
    cnt_d = cnt_q;
    if (stall_out && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
      aluop_q    <= '0;
      ctrl_q     <= '0;
      cnt_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (bubble) begin
        // Data fields hold; only the control that makes the slot live is cleared.
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        aluop_q <= '0;
        funct_q <= '0;
      end else begin
        valid_q    <= id_valid;
        pc_q       <= id_pc;
        rs1_data_q <= id_rs1_data;
        rs2_data_q <= id_rs2_data;
        imm_q      <= id_imm;
        rs1_q      <= id_rs1;
        rs2_q      <= id_rs2;
        rd_q       <= id_rd;
        ctrl_q     <= id_valid ? id_ctrl  : 6'd0;
        aluop_q    <= id_valid ? id_ALUOp : 4'd0;
        funct_q    <= id_valid ? id_Funct : 4'd0;
      end
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_Funct    = funct_q;
  assign ex_ALUOp    = aluop_q;
  assign ex_ctrl     = ctrl_q;
  assign stall_count = cnt_q;

endmodule
